regfile_bank: RTL and testbench

//  - Parametrised register file: NUM_REGS x WIDTH storage, one synchronous write port, two

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_bank_dffe_vec.sv | 19 +
 rtl/regfile_bank.sv | 58 +++++
 tb/tb_regfile_bank.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the register file bank
package regfile_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int ZERO_IDX     = 0;

  function automatic int addr_width(input int num_regs);
    return $clog2(num_regs);
  endfunction

endpackage

// File: rtl/regfile_bank_dffe_vec.sv
// rtl/regfile_bank_dffe_vec.sv - WIDTH-bit enabled register with asynchronous active-high clear
module dffe_vec #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - NUM_REGS x WIDTH register file, one write port, two combinational read ports
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0,
  localparam int AW      = addr_width(NUM_REGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] q [NUM_REGS];

  // Entry 0 has no storage when hardwired to zero.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
    if (ZERO_REG != 0 && i == ZERO_IDX) begin : g_zero
      assign q[i] = '0;
    end else begin : g_reg
      logic en;
      assign en = we & (waddr == AW'(i));
      dffe_vec #(.WIDTH(WIDTH)) u_reg (
        .d   (wdata),
        .clk (clk),
        .clr (clr),
        .en  (en),
        .q   (q[i])
      );
    end
  end

  // Zero override is applied last so it also masks the bypass path.
  always_comb begin
    rdata_a = q[raddr_a];
    if (BYPASS != 0 && !clr && we && raddr_a == waddr)
      rdata_a = wdata;
    if (ZERO_REG != 0 && raddr_a == AW'(ZERO_IDX))
      rdata_a = '0;
  end

  always_comb begin
    rdata_b = q[raddr_b];
    if (BYPASS != 0 && !clr && we && raddr_b == waddr)
      rdata_b = wdata;
    if (ZERO_REG != 0 && raddr_b == AW'(ZERO_IDX))
      rdata_b = '0;
  end

endmodule

// File: tb/tb_regfile_bank.sv
// tb/tb_regfile_bank.sv - randomized self-checking bench for regfile_bank against an array model
module tb_regfile_bank;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr_a = '0;
  logic [4:0]  raddr_b = '0;
  logic [31:0] ro_a, ro_b, rb_a, rb_b;

  logic        we2 = 1'b0;
  logic [1:0]  waddr2 = '0;
  logic [7:0]  wdata2 = '0;
  logic [1:0]  raddr2_a = '0;
  logic [1:0]  raddr2_b = '0;
  logic [7:0]  r2_a, r2_b;

  logic [31:0] mem  [32];
  logic [7:0]  mem2 [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_bank #(.WIDTH(32), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(0)) dut_old (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ro_a), .rdata_b(ro_b));

  regfile_bank #(.WIDTH(32), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(1)) dut_byp (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rb_a), .rdata_b(rb_b));

  regfile_bank #(.WIDTH(8), .NUM_REGS(4), .ZERO_REG(0), .BYPASS(0)) dut_small (
    .clk(clk), .clr(clr), .we(we2), .waddr(waddr2), .wdata(wdata2),
    .raddr_a(raddr2_a), .raddr_b(raddr2_b), .rdata_a(r2_a), .rdata_b(r2_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected read value of the 32-entry bank straight from the behavioural rules.
  function automatic logic [31:0] expect_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0 || clr) return 32'h0;
    if (byp && we && a == waddr) return wdata;
    return mem[a];
  endfunction

  function automatic logic [7:0] expect_rd2(input logic [1:0] a);
    if (clr) return 8'h0;
    return mem2[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem2[i] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    if (!clr && we && waddr != 5'd0) mem[waddr] = wdata;
    if (!clr && we2) mem2[waddr2] = wdata2;
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic check_reads(input string tag);
    #1;
    check({tag, "_old_a"}, ro_a, expect_rd(raddr_a, 1'b0));
    check({tag, "_old_b"}, ro_b, expect_rd(raddr_b, 1'b0));
    check({tag, "_byp_a"}, rb_a, expect_rd(raddr_a, 1'b1));
    check({tag, "_byp_b"}, rb_b, expect_rd(raddr_b, 1'b1));
  endtask

  task automatic sweep_reads(input string tag);
    for (int a = 0; a < 32; a++) begin
      raddr_a = 5'(a);
      raddr_b = 5'(31 - a);
      check_reads(tag);
    end
  endtask

  task automatic sweep_reads2(input string tag);
    for (int a = 0; a < 4; a++) begin
      raddr2_a = 2'(a);
      raddr2_b = 2'(3 - a);
      #1;
      check({tag, "_a"}, {24'h0, r2_a}, {24'h0, expect_rd2(raddr2_a)});
      check({tag, "_b"}, {24'h0, r2_b}, {24'h0, expect_rd2(raddr2_b)});
    end
  endtask

  initial begin
    clear_model();
    #2;
    sweep_reads("reset");
    @(negedge clk);
    clr = 1'b0;

    for (int i = 1; i < 32; i++) write(5'(i), 32'hA5A5_0000 + i);
    sweep_reads("preload");

    // clr asserted mid-cycle clears at once and blocks writes and bypass
    #2 clr = 1'b1;
    clear_model();
    sweep_reads("clr_mid");
    we = 1'b1; waddr = 5'd3; wdata = 32'hDEAD_BEEF; raddr_a = 5'd3; raddr_b = 5'd3;
    check_reads("clr_byp");
    step();
    we = 1'b0;
    check_reads("clr_wr");
    @(negedge clk);
    clr = 1'b0;

    // clr rising on the same edge as a write
    write(5'd9, 32'h0000_9999);
    we = 1'b1; waddr = 5'd9; wdata = 32'h1234_5678;
    @(posedge clk);
    clr = 1'b1;
    we = 1'b0;
    clear_model();
    #1 raddr_a = 5'd9; raddr_b = 5'd9;
    check_reads("clr_edge");
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < 32; i++) write(5'(i), i * 32'h0101_0101);
    sweep_reads("sweep");

    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr_a = 5'd0; raddr_b = 5'd0;
    #1;
    check("zero_pre_old", ro_a, 32'h0);
    check("zero_pre_byp", rb_a, 32'h0);
    step();
    we = 1'b0;
    #1;
    check("zero_post_old", ro_a, 32'h0);
    check("zero_post_byp", rb_b, 32'h0);

    write(5'd5, 32'h1111_1111);
    we = 1'b1; waddr = 5'd5; wdata = 32'h2222_2222; raddr_a = 5'd5; raddr_b = 5'd5;
    #1;
    check("haz_pre_old_a", ro_a, 32'h1111_1111);
    check("haz_pre_old_b", ro_b, 32'h1111_1111);
    check("haz_pre_byp_a", rb_a, 32'h2222_2222);
    check("haz_pre_byp_b", rb_b, 32'h2222_2222);
    step();
    we = 1'b0;
    #1;
    check("haz_post_old", ro_a, 32'h2222_2222);
    check("haz_post_byp", rb_b, 32'h2222_2222);

    for (int c = 0; c < 10; c++) begin
      we = 1'b0; waddr = 5'($urandom); wdata = $urandom;
      step();
    end
    sweep_reads("isolate");

    write(5'd7, $urandom);
    sweep_reads("disturb");

    for (int c = 0; c < 300; c++) begin
      we = 1'($urandom); waddr = 5'($urandom); wdata = $urandom;
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      raddr_b = 5'($urandom);
      check_reads("rand");
      step();
    end
    we = 1'b0;
    sweep_reads("rand_final");

    for (int i = 0; i < 4; i++) begin
      we2 = 1'b1; waddr2 = 2'(i); wdata2 = 8'(8'h41 * (i + 1));
      step();
    end
    we2 = 1'b0;
    sweep_reads2("small_sweep");
    for (int c = 0; c < 100; c++) begin
      we2 = 1'($urandom); waddr2 = 2'($urandom); wdata2 = 8'($urandom);
      raddr2_a = 2'($urandom); raddr2_b = 2'($urandom);
      #1;
      check("small_rand_a", {24'h0, r2_a}, {24'h0, expect_rd2(raddr2_a)});
      check("small_rand_b", {24'h0, r2_b}, {24'h0, expect_rd2(raddr2_b)});
      step();
    end
    we2 = 1'b0;
    sweep_reads2("small_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
